uart_wb_loader: RTL and testbench

- Receives 8x8 frame data over a serial line (ESP32 or FTDI UART) and writes it into the matrix framebuffer.
- Acts as a Wishbone pipelined master that sits directly upstream of the matrix slave, as an alternative to the move_master pattern source.
- Each accepted packet produces one 32-bit full-word write to one of the 8 row addresses.

---
 rtl/uart_wb_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_wb_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_loader.sv
// uart_wb_loader: receives 8N1 UART packets (A5, ADDR, D3, D2, D1, D0) and
// issues one 32-bit Wishbone pipelined write per packet to a row address.
// Optional build macro UART_WB_LOADER_CKSUM_EN adds a trailing XOR checksum
// byte (CK = ADDR^D3^D2^D1^D0) verified before the bus cycle is started.
module uart_wb_loader #(
  parameter int CLK_HZ      = 100000000,
  parameter int BAUD        = 115200,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rx,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_addr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_wdata,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_rdata,
  output logic        o_busy,
  output logic        o_err,
  output logic [7:0]  o_wr_count
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef UART_WB_LOADER_CKSUM_EN
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_CKSUM, P_WB_REQ, P_WB_WAIT} p_state_t;
`else
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_WB_REQ, P_WB_WAIT} p_state_t;
`endif

  // Read data is never consumed by a write-only master.
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_wb_rdata;

  logic            r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t       r_rx_state, w_rx_next;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_cnt_clr, w_rx_sample, w_rx_valid, w_rx_ferr;
  logic [7:0]      w_rx_byte;

  p_state_t        r_pstate, w_p_next;
  logic            r_cyc, r_stb, r_err;
  logic [7:0]      r_count;
  logic [2:0]      r_addr;
  logic [31:0]     r_data;
  logic [1:0]      r_dcnt;
  logic [TW-1:0]   r_to_cnt;
  logic            w_cyc_nxt, w_stb_nxt, w_err_nxt;
  logic            w_done, w_addr_ld, w_data_ld, w_to_clr;

  assign w_rx_byte = r_rx_shift;

  // RX next-state: start check at half bit, data and stop sampled at mid-bit.
  always_comb begin
    w_rx_next    = r_rx_state;
    w_rx_cnt_clr = 1'b0;
    w_rx_sample  = 1'b0;
    w_rx_valid   = 1'b0;
    w_rx_ferr    = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
        w_rx_next    = RX_START;
        w_rx_cnt_clr = 1'b1;
      end
      RX_START: if (r_rx_cnt == CW'(HALF_BIT - 1)) begin
        w_rx_cnt_clr = 1'b1;
        w_rx_next    = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
        w_rx_cnt_clr = 1'b1;
        w_rx_sample  = 1'b1;
        if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      end
      RX_STOP: if (r_rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
        w_rx_cnt_clr = 1'b1;
        w_rx_next    = RX_IDLE;
        w_rx_valid   = r_rx_s2;
        w_rx_ferr    = !r_rx_s2;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // RX synchronizer, state register, bit timer and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
    end else begin
      r_rx_s1    <= i_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_next;
      r_rx_cnt   <= w_rx_cnt_clr ? '0 : r_rx_cnt + CW'(1);
      if (r_rx_state == RX_START) r_rx_bit <= 3'd0;
      if (w_rx_sample)            r_rx_bit <= r_rx_bit + 3'd1;
    end
    if (w_rx_sample) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
  end

`ifdef UART_WB_LOADER_CKSUM_EN
  logic [7:0] w_ck;
  assign w_ck = {5'd0, r_addr} ^ r_data[31:24] ^ r_data[23:16] ^ r_data[15:8] ^ r_data[7:0];
`endif

  // Parser next-state and bus control; framing errors abort a partial packet.
  always_comb begin
    w_p_next  = r_pstate;
    w_cyc_nxt = r_cyc;
    w_stb_nxt = r_stb;
    w_err_nxt = w_rx_ferr;
    w_done    = 1'b0;
    w_addr_ld = 1'b0;
    w_data_ld = 1'b0;
    w_to_clr  = 1'b0;
    case (r_pstate)
      P_IDLE: if (w_rx_valid && w_rx_byte == SYNC_BYTE) w_p_next = P_ADDR;
      P_ADDR: begin
        if (w_rx_ferr) w_p_next = P_IDLE;
        else if (w_rx_valid) begin
          if (w_rx_byte[7:3] != 5'd0) begin
            w_err_nxt = 1'b1;
            w_p_next  = P_IDLE;
          end else begin
            w_addr_ld = 1'b1;
            w_p_next  = P_DATA;
          end
        end
      end
      P_DATA: begin
        if (w_rx_ferr) w_p_next = P_IDLE;
        else if (w_rx_valid) begin
          w_data_ld = 1'b1;
          if (r_dcnt == 2'd3) begin
`ifdef UART_WB_LOADER_CKSUM_EN
            w_p_next  = P_CKSUM;
`else
            w_p_next  = P_WB_REQ;
            w_cyc_nxt = 1'b1;
            w_stb_nxt = 1'b1;
`endif
          end
        end
      end
`ifdef UART_WB_LOADER_CKSUM_EN
      P_CKSUM: begin
        if (w_rx_ferr) w_p_next = P_IDLE;
        else if (w_rx_valid) begin
          if (w_rx_byte == w_ck) begin
            w_p_next  = P_WB_REQ;
            w_cyc_nxt = 1'b1;
            w_stb_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
            w_p_next  = P_IDLE;
          end
        end
      end
`endif
      P_WB_REQ: begin
        if (w_rx_valid) w_err_nxt = 1'b1;
        if (!i_wb_stall) begin
          w_stb_nxt = 1'b0;
          w_to_clr  = 1'b1;
          if (i_wb_ack) begin
            w_cyc_nxt = 1'b0;
            w_done    = 1'b1;
            w_p_next  = P_IDLE;
          end else begin
            w_p_next  = P_WB_WAIT;
          end
        end
      end
      P_WB_WAIT: begin
        if (w_rx_valid) w_err_nxt = 1'b1;
        if (i_wb_ack) begin
          w_cyc_nxt = 1'b0;
          w_done    = 1'b1;
          w_p_next  = P_IDLE;
        end else if (r_to_cnt == TW'(ACK_TIMEOUT - 1)) begin
          w_cyc_nxt = 1'b0;
          w_err_nxt = 1'b1;
          w_p_next  = P_IDLE;
        end
      end
      default: w_p_next = P_IDLE;
    endcase
  end

  // Parser state, bus registers, packet fields and ack timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pstate <= P_IDLE;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= 8'd0;
      r_addr   <= 3'd0;
      r_data   <= 32'd0;
      r_dcnt   <= 2'd0;
      r_to_cnt <= '0;
    end else begin
      r_pstate <= w_p_next;
      r_cyc    <= w_cyc_nxt;
      r_stb    <= w_stb_nxt;
      r_err    <= w_err_nxt;
      r_to_cnt <= w_to_clr ? '0 : r_to_cnt + TW'(1);
      if (w_done) r_count <= r_count + 8'd1;
      if (w_addr_ld) begin
        r_addr <= w_rx_byte[2:0];
        r_dcnt <= 2'd0;
      end
      if (w_data_ld) begin
        r_data <= {r_data[23:0], w_rx_byte};
        r_dcnt <= r_dcnt + 2'd1;
      end
    end
  end

  assign o_wb_cyc   = r_cyc;
  assign o_wb_stb   = r_stb;
  assign o_wb_we    = r_cyc;
  assign o_wb_sel   = {4{r_cyc}};
  assign o_wb_addr  = r_addr;
  assign o_wb_wdata = r_data;
  assign o_busy     = (r_pstate != P_IDLE);
  assign o_err      = r_err;
  assign o_wr_count = r_count;
endmodule

// File: tb/tb_uart_wb_loader.sv
// Bench for uart_wb_loader: UART byte driver, reactive Wishbone slave and a
// write scoreboard checked whenever the master's strobe is accepted.
module tb_uart_wb_loader;
  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 100000;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_rx = 1'b1;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_stall = 1'b0;
  logic [31:0] i_wb_rdata = 32'h0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_err;
  logic [2:0]  o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_wdata;
  logic [7:0]  o_wr_count;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  int total = 0, bad = 0;
  int ncnt = 0, err_cnt = 0, ack_used = 0, accept_cnt = 0, fall_cnt = 0;
  int stb_hi = 0, last_stb_hi = 0, t_accept = 0, t_fall = 0;
  int stall_left = 0, ack_mode = 0, exp_count = 0;
  logic prev_cyc = 1'b0;

  uart_wb_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_rx(i_rx),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_rdata(i_wb_rdata),
    .o_busy(o_busy), .o_err(o_err), .o_wr_count(o_wr_count)
  );

  always #5 clk = ~clk;

  // Slave response (ack_mode 0: ack after accept, 1: never, 2: same cycle) and monitor.
  always @(negedge clk) begin
    wr_t e;
    ncnt++;
    i_wb_stall = 1'b0;
    if (o_wb_cyc && o_wb_stb && stall_left > 0) begin
      i_wb_stall = 1'b1;
      stall_left--;
    end
    i_wb_ack = 1'b0;
    if (ack_mode == 0 && o_wb_cyc && !o_wb_stb) i_wb_ack = 1'b1;
    if (ack_mode == 2 && o_wb_cyc && o_wb_stb && !i_wb_stall) i_wb_ack = 1'b1;
    if (o_wb_cyc && i_wb_ack) ack_used++;
    if (o_err) err_cnt++;
    if (o_wb_cyc && !prev_cyc) stb_hi = 0;
    if (o_wb_cyc && o_wb_stb) stb_hi++;
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      accept_cnt++;
      t_accept = ncnt;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d wdata=%h, no write expected", o_wb_addr, o_wb_wdata);
      end else begin
        e = sb.pop_front();
        if (o_wb_addr !== e.addr) begin
          bad++;
          $display("FAIL wr_addr got=%0d want=%0d", o_wb_addr, e.addr);
        end
        total++;
        if (o_wb_wdata !== e.data) begin
          bad++;
          $display("FAIL wr_data got=%h want=%h", o_wb_wdata, e.data);
        end
        total++;
        if (o_wb_sel !== 4'hF || o_wb_we !== 1'b1) begin
          bad++;
          $display("FAIL wr_sel_we got sel=%h we=%b want sel=f we=1", o_wb_sel, o_wb_we);
        end
      end
    end
    if (!o_wb_cyc && prev_cyc) begin
      fall_cnt++;
      t_fall = ncnt;
      last_stb_hi = stb_hi;
      total++;
      if (o_wb_we !== 1'b0 || o_wb_sel !== 4'h0) begin
        bad++;
        $display("FAIL idle_we_sel got we=%b sel=%h want 0/0", o_wb_we, o_wb_sel);
      end
    end
    prev_cyc = o_wb_cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time expired, got no finish want finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stop;
    repeat (CPB) @(negedge clk);
    i_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] a, input logic [31:0] d);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d[31:24], 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
`ifdef UART_WB_LOADER_CKSUM_EN
    send_byte(a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0], 1'b1);
`endif
  endtask

  task automatic wait_fall(input int f0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fall_cnt != f0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000", {o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_err});
    end
    total++;
    if (o_wb_addr !== 3'd0 || o_wb_sel !== 4'd0 || o_wb_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_bus got addr=%0d sel=%h wdata=%h want 0", o_wb_addr, o_wb_sel, o_wb_wdata);
    end
    total++;
    if (o_wr_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", o_wr_count);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write(input string nm, input int stall, input int mode,
                            input logic [7:0] a, input logic [31:0] d, input int want_stb);
    int f0, e0, a0;
    bit ok;
    stall_left = stall;
    ack_mode   = mode;
    f0 = fall_cnt; e0 = err_cnt; a0 = ack_used;
    sb.push_back('{a[2:0], d});
    send_packet(a, d);
    wait_fall(f0, 1000, ok);
    exp_count++;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_done got no cyc fall want cyc fall", nm);
    end
    total++;
    if (o_wr_count !== exp_count[7:0]) begin
      bad++;
      $display("FAIL %s_count got=%0d want=%0d", nm, o_wr_count, exp_count);
    end
    total++;
    if (ack_used - a0 != 1) begin
      bad++;
      $display("FAIL %s_acks got=%0d want=1", nm, ack_used - a0);
    end
    total++;
    if (last_stb_hi != want_stb) begin
      bad++;
      $display("FAIL %s_stb_cycles got=%0d want=%0d", nm, last_stb_hi, want_stb);
    end
    total++;
    if (err_cnt != e0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_err_busy got err=%0d busy=%b want err=0 busy=0", nm, err_cnt - e0, o_busy);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_sb_left got=%0d want=0", nm, sb.size());
    end
  endtask

  task automatic test_bad_addr();
    int e0, c0;
    e0 = err_cnt; c0 = accept_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b1);
    total++;
    if (err_cnt != e0) begin
      bad++;
      $display("FAIL badaddr_early_err got=%0d want=0", err_cnt - e0);
    end
    send_byte(8'h09, 1'b1);
    total++;
    if (err_cnt - e0 != 1) begin
      bad++;
      $display("FAIL badaddr_err got=%0d want=1", err_cnt - e0);
    end
    total++;
    if (accept_cnt != c0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL badaddr_idle got writes=%0d busy=%b want 0/0", accept_cnt - c0, o_busy);
    end
  endtask

  task automatic test_framing();
    int e0;
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'hAA, 1'b0);
    total++;
    if (err_cnt - e0 != 1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL framing_err got err=%0d busy=%b want 1/0", err_cnt - e0, o_busy);
    end
    test_write("after_frame", 0, 0, 8'h07, 32'hAABBCCDD, 1);
  endtask

  task automatic test_timeout();
    int f0, e0;
    bit ok;
    stall_left = 0;
    ack_mode   = 1;
    f0 = fall_cnt; e0 = err_cnt;
    sb.push_back('{3'd5, 32'h000000FF});
    send_packet(8'h05, 32'h000000FF);
    send_byte(8'h55, 1'b1);
    wait_fall(f0, 1000, ok);
    total++;
    if (!ok || t_fall - 1 - t_accept != TIMEOUT) begin
      bad++;
      $display("FAIL timeout_len got=%0d (fell=%0d) want=%0d", t_fall - 1 - t_accept, ok, TIMEOUT);
    end
    total++;
    if (err_cnt - e0 != 2) begin
      bad++;
      $display("FAIL timeout_overrun_err got=%0d want=2", err_cnt - e0);
    end
    total++;
    if (o_wr_count !== exp_count[7:0] || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_count got=%0d busy=%b want=%0d busy=0", o_wr_count, o_busy, exp_count);
    end
    ack_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    ack_mode = 1;
    stall_left = 0;
    sb.push_back('{3'd2, 32'hCAFEF00D});
    send_packet(8'h02, 32'hCAFEF00D);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (o_wb_cyc && !o_wb_stb) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rstmid_wait got no WB_WAIT want WB_WAIT");
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_drop got cyc=%b stb=%b want 0/0", o_wb_cyc, o_wb_stb);
    end
    total++;
    if (o_wr_count !== 8'd0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_state got count=%0d busy=%b want 0/0", o_wr_count, o_busy);
    end
    reset = 1'b0;
    exp_count = 0;
    ack_mode = 0;
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rstmid_sb_left got=%0d want=0", sb.size());
    end
  endtask

`ifdef UART_WB_LOADER_CKSUM_EN
  task automatic test_cksum();
    int e0, c0;
    test_write("cksum_ok", 0, 0, 8'h01, 32'h00000001, 1);
    e0 = err_cnt; c0 = accept_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (10) @(negedge clk);
    total++;
    if (err_cnt - e0 != 1 || accept_cnt != c0) begin
      bad++;
      $display("FAIL cksum_bad got err=%0d writes=%0d want 1/0", err_cnt - e0, accept_cnt - c0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write("basic", 0, 0, 8'h03, 32'h12345678, 1);
    test_write("stall", 5, 0, 8'h03, 32'h12345678, 6);
    test_bad_addr();
    test_framing();
    test_write("same_ack", 0, 2, 8'h00, 32'hDEADBEEF, 1);
    test_timeout();
    test_reset_mid();
`ifdef UART_WB_LOADER_CKSUM_EN
    test_cksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
